// File: rtl/prach_pkg.sv
// rtl/prach_pkg.sv - shared constants, types and commit states for the PRACH FCW controller
package prach_pkg;

    localparam int N_LANE = 3;
    localparam int N_CHN  = 8;
    localparam int FCW_W  = 16;
    localparam int LANE_W = 2;
    localparam int CHN_W  = 3;

    typedef logic [FCW_W-1:0] fcw_t;
    typedef fcw_t fcw_bank_t [N_LANE][N_CHN];

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        APPLY
    } commit_state_e;

    function automatic logic lane_ok(input logic [LANE_W-1:0] lane);
        return int'(lane) < N_LANE;
    endfunction

endpackage

// File: rtl/prach_fcw_ctrl_if.sv
// rtl/prach_fcw_ctrl_if.sv - CSR-side write/commit/readback bus plus the active FCW bank to the mixer
interface prach_fcw_ctrl_if;
    import prach_pkg::*;

    logic               sync_in;
    logic               wr_en;
    logic [LANE_W-1:0]  wr_lane;
    logic [CHN_W-1:0]   wr_chn;
    fcw_t               wr_data;
    logic               wr_err;
    logic               commit_req;
    logic               commit_ack;
    logic               commit_err;
    logic               busy;
    logic               phase_clr;
    logic               rd_en;
    logic               rd_bank;
    logic [LANE_W-1:0]  rd_lane;
    logic [CHN_W-1:0]   rd_chn;
    fcw_t               rd_data;
    logic               rd_valid;
    fcw_bank_t          ctrl_fcw;

    modport master (
        output sync_in, wr_en, wr_lane, wr_chn, wr_data, commit_req,
               rd_en, rd_bank, rd_lane, rd_chn,
        input  wr_err, commit_ack, commit_err, busy, phase_clr,
               rd_data, rd_valid, ctrl_fcw
    );

    modport slave (
        input  sync_in, wr_en, wr_lane, wr_chn, wr_data, commit_req,
               rd_en, rd_bank, rd_lane, rd_chn,
        output wr_err, commit_ack, commit_err, busy, phase_clr,
               rd_data, rd_valid, ctrl_fcw
    );

endinterface

// File: rtl/prach_fcw_bank.sv
// rtl/prach_fcw_bank.sv - shadow and active FCW storage with bulk copy and registered readback
module prach_fcw_bank
    import prach_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en_i,
    input  logic [LANE_W-1:0]  wr_lane_i,
    input  logic [CHN_W-1:0]   wr_chn_i,
    input  fcw_t               wr_data_i,
    input  logic               copy_en_i,
    input  logic               rd_en_i,
    input  logic               rd_bank_i,
    input  logic [LANE_W-1:0]  rd_lane_i,
    input  logic [CHN_W-1:0]   rd_chn_i,
    output fcw_t               rd_data_o,
    output logic               rd_valid_o,
    output fcw_bank_t          active_o
);

    fcw_bank_t shadow_q;
    fcw_bank_t active_q;
    fcw_t      rd_data_q;
    logic      rd_valid_q;
    fcw_t      rd_word_d;

    always_comb begin
        rd_word_d = '0;
        if (lane_ok(rd_lane_i)) begin
            rd_word_d = rd_bank_i ? active_q[rd_lane_i][rd_chn_i]
                                  : shadow_q[rd_lane_i][rd_chn_i];
        end
    end

    // Copy reads shadow_q before this edge's write lands, so a write in the
    // copy cycle only reaches the shadow bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q   <= '{default: '0};
            active_q   <= '{default: '0};
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            if (copy_en_i) begin
                active_q <= shadow_q;
            end
            if (wr_en_i) begin
                shadow_q[wr_lane_i][wr_chn_i] <= wr_data_i;
            end
            rd_valid_q <= rd_en_i;
            if (rd_en_i) begin
                rd_data_q <= rd_word_d;
            end
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign active_o   = active_q;

endmodule

// File: rtl/prach_fcw_ctrl.sv
// rtl/prach_fcw_ctrl.sv - commit FSM that swaps shadow FCWs into the active bank on frame sync
module prach_fcw_ctrl
    import prach_pkg::*;
#(
    parameter int TMO_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    prach_fcw_ctrl_if.slave    bus
);

    commit_state_e    state_q;
    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;
    logic             wr_err_q;
    logic             ack_q;
    logic             cerr_q;
    logic             busy_q;
    logic             pclr_q;
    logic             wr_ok;
    logic             timeout;

    assign wr_ok   = bus.wr_en && (state_q != ARMED) && lane_ok(bus.wr_lane);
    assign cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + TMO_W'(1);
    assign timeout = (cnt_d == '1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wr_err_q <= 1'b0;
            ack_q    <= 1'b0;
            cerr_q   <= 1'b0;
            busy_q   <= 1'b0;
            pclr_q   <= 1'b0;
        end else begin
            ack_q    <= 1'b0;
            pclr_q   <= 1'b0;
            cerr_q   <= 1'b0;
            wr_err_q <= bus.wr_en && !wr_ok;
            unique case (state_q)
                IDLE: begin
                    if (bus.commit_req) begin
                        state_q <= ARMED;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ARMED: begin
                    if (bus.commit_req) begin
                        cerr_q <= 1'b1;
                    end
                    // A sync arriving on the last counted cycle still wins over the timeout.
                    if (bus.sync_in) begin
                        state_q <= APPLY;
                        busy_q  <= 1'b0;
                        ack_q   <= 1'b1;
                        pclr_q  <= 1'b1;
                    end else if (timeout) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cerr_q  <= 1'b1;
                        cnt_q   <= cnt_d;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                APPLY: begin
                    if (bus.commit_req) begin
                        cerr_q <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    prach_fcw_bank u_bank (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (wr_ok),
        .wr_lane_i  (bus.wr_lane),
        .wr_chn_i   (bus.wr_chn),
        .wr_data_i  (bus.wr_data),
        .copy_en_i  (state_q == APPLY),
        .rd_en_i    (bus.rd_en),
        .rd_bank_i  (bus.rd_bank),
        .rd_lane_i  (bus.rd_lane),
        .rd_chn_i   (bus.rd_chn),
        .rd_data_o  (bus.rd_data),
        .rd_valid_o (bus.rd_valid),
        .active_o   (bus.ctrl_fcw)
    );

    assign bus.wr_err     = wr_err_q;
    assign bus.commit_ack = ack_q;
    assign bus.commit_err = cerr_q;
    assign bus.busy       = busy_q;
    assign bus.phase_clr  = pclr_q;

endmodule

// File: tb/tb_prach_fcw_ctrl.sv
// tb/tb_prach_fcw_ctrl.sv - directed and randomized checks of commit, timeout, write and readback rules
module tb_prach_fcw_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cmp_cnt = 0;
    int   err_cnt = 0;

    logic [15:0] m_sh  [3][8];
    logic [15:0] m_act [3][8];

    prach_fcw_ctrl_if bus ();

    prach_fcw_ctrl #(.TMO_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmp_cnt++;
        assert (got === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int l = 0; l < 3; l++)
            for (int c = 0; c < 8; c++) begin
                m_sh[l][c]  = '0;
                m_act[l][c] = '0;
            end
    endtask

    task automatic model_copy();
        for (int l = 0; l < 3; l++)
            for (int c = 0; c < 8; c++)
                m_act[l][c] = m_sh[l][c];
    endtask

    task automatic check_active(input string tag);
        for (int l = 0; l < 3; l++)
            for (int c = 0; c < 8; c++)
                check($sformatf("%s[%0d][%0d]", tag, l, c), bus.ctrl_fcw[l][c], m_act[l][c]);
    endtask

    task automatic wr(input int l, input int c, input logic [15:0] d);
        logic [31:0] lv;
        logic [31:0] cv;
        lv = l;
        cv = c;
        bus.wr_en = 1'b1;
        bus.wr_lane = lv[1:0];
        bus.wr_chn = cv[2:0];
        bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic rd(input logic bank, input int l, input int c, input logic [15:0] exp, input string tag);
        logic [31:0] lv;
        logic [31:0] cv;
        lv = l;
        cv = c;
        bus.rd_en = 1'b1;
        bus.rd_bank = bank;
        bus.rd_lane = lv[1:0];
        bus.rd_chn = cv[2:0];
        tick();
        bus.rd_en = 1'b0;
        check({tag, "_vld"}, bus.rd_valid, 1);
        check(tag, bus.rd_data, exp);
    endtask

    initial begin
        int l;
        int c;
        int dly;
        logic [15:0] d;
        logic [15:0] old;
        int rl;
        int rc;

        bus.sync_in = 0; bus.wr_en = 0; bus.wr_lane = 0; bus.wr_chn = 0; bus.wr_data = 0;
        bus.commit_req = 0; bus.rd_en = 0; bus.rd_bank = 0; bus.rd_lane = 0; bus.rd_chn = 0;
        model_clear();

        // Reset state
        tick(); tick();
        rst = 1'b0;
        check("rst_busy", bus.busy, 0);
        check("rst_ack", bus.commit_ack, 0);
        check("rst_cerr", bus.commit_err, 0);
        check("rst_werr", bus.wr_err, 0);
        check("rst_pclr", bus.phase_clr, 0);
        check("rst_rvld", bus.rd_valid, 0);
        check("rst_rdata", bus.rd_data, 0);
        for (int i = 0; i < 24; i++)
            rd(1'b1, i / 8, i % 8, 16'h0, $sformatf("rst_act%0d", i));
        check_active("rst_ctrl");

        // Basic commit with sync 10 cycles after the request
        wr(1, 5, 16'h1234);
        m_sh[1][5] = 16'h1234;
        check("basic_werr", bus.wr_err, 0);
        bus.commit_req = 1; tick(); bus.commit_req = 0;
        check("basic_busy", bus.busy, 1);
        repeat (9) tick();
        check("basic_busy_wait", bus.busy, 1);
        check("basic_noack", bus.commit_ack, 0);
        bus.sync_in = 1; tick(); bus.sync_in = 0;
        check("basic_ack", bus.commit_ack, 1);
        check("basic_pclr", bus.phase_clr, 1);
        check("basic_busy_apply", bus.busy, 0);
        check("basic_old_fcw", bus.ctrl_fcw[1][5], 0);
        tick();
        model_copy();
        check("basic_ack_end", bus.commit_ack, 0);
        check("basic_pclr_end", bus.phase_clr, 0);
        check_active("basic_ctrl");

        // Timeout after 15 ARMED cycles, active bank untouched
        wr(2, 3, 16'hCAFE);
        m_sh[2][3] = 16'hCAFE;
        bus.commit_req = 1; tick(); bus.commit_req = 0;
        check("tmo_busy0", bus.busy, 1);
        for (int k = 1; k <= 15; k++) begin
            tick();
            check($sformatf("tmo_err_%0d", k), bus.commit_err, (k == 15) ? 1 : 0);
            check($sformatf("tmo_busy_%0d", k), bus.busy, (k == 15) ? 0 : 1);
        end
        tick();
        check("tmo_err_end", bus.commit_err, 0);
        check("tmo_ack", bus.commit_ack, 0);
        check_active("tmo_ctrl");

        // Write dropped while ARMED, second request rejected, commit completes
        wr(0, 0, 16'h0A0A);
        m_sh[0][0] = 16'h0A0A;
        bus.commit_req = 1; tick(); bus.commit_req = 0;
        wr(0, 0, 16'hBEEF);
        check("armed_werr", bus.wr_err, 1);
        tick();
        check("armed_werr_end", bus.wr_err, 0);
        bus.commit_req = 1; tick(); bus.commit_req = 0;
        check("armed_req_err", bus.commit_err, 1);
        check("armed_req_busy", bus.busy, 1);
        bus.sync_in = 1; tick(); bus.sync_in = 0;
        check("armed_ack", bus.commit_ack, 1);
        tick();
        model_copy();
        check_active("armed_ctrl");
        rd(1'b0, 0, 0, 16'h0A0A, "armed_shadow");

        // Out-of-range lane
        wr(3, 2, 16'h7777);
        check("oor_werr", bus.wr_err, 1);
        rd(1'b0, 3, 2, 16'h0, "oor_rd");

        // commit_req and sync together: that sync is not used
        bus.commit_req = 1; bus.sync_in = 1; tick();
        bus.commit_req = 0; bus.sync_in = 0;
        check("same_ack0", bus.commit_ack, 0);
        check("same_busy0", bus.busy, 1);
        repeat (3) tick();
        check("same_ack_wait", bus.commit_ack, 0);
        check("same_busy_wait", bus.busy, 1);
        bus.sync_in = 1; tick(); bus.sync_in = 0;
        check("same_ack", bus.commit_ack, 1);
        tick();
        model_copy();

        // Randomized rounds: writes, commit, write+read in the APPLY cycle
        for (int r = 0; r < 8; r++) begin
            for (int w = 0; w < 4; w++) begin
                l = $urandom_range(0, 3);
                c = $urandom_range(0, 7);
                d = 16'($urandom);
                wr(l, c, d);
                if (l < 3) m_sh[l][c] = d;
                check($sformatf("rnd%0d_werr%0d", r, w), bus.wr_err, (l >= 3) ? 1 : 0);
            end
            bus.commit_req = 1; tick(); bus.commit_req = 0;
            dly = $urandom_range(0, 13);
            repeat (dly) tick();
            bus.sync_in = 1; tick(); bus.sync_in = 0;
            check($sformatf("rnd%0d_ack", r), bus.commit_ack, 1);
            rl = $urandom_range(0, 2);
            rc = $urandom_range(0, 7);
            old = m_act[rl][rc];
            l = $urandom_range(0, 2);
            c = $urandom_range(0, 7);
            d = 16'($urandom);
            bus.rd_en = 1; bus.rd_bank = 1; bus.rd_lane = rl[1:0]; bus.rd_chn = rc[2:0];
            bus.wr_en = 1; bus.wr_lane = l[1:0]; bus.wr_chn = c[2:0]; bus.wr_data = d;
            tick();
            bus.rd_en = 0; bus.wr_en = 0;
            model_copy();
            m_sh[l][c] = d;
            check($sformatf("rnd%0d_apply_rd", r), bus.rd_data, old);
            check($sformatf("rnd%0d_apply_werr", r), bus.wr_err, 0);
            check_active($sformatf("rnd%0d_ctrl", r));
            rd(1'b0, l, c, d, $sformatf("rnd%0d_sh", r));
            rl = $urandom_range(0, 2);
            rc = $urandom_range(0, 7);
            rd(1'b1, rl, rc, m_act[rl][rc], $sformatf("rnd%0d_act", r));
        end

        // Reset while ARMED abandons the commit
        wr(1, 1, 16'h5555);
        bus.commit_req = 1; tick(); bus.commit_req = 0;
        rst = 1; tick(); rst = 0;
        model_clear();
        check("rarm_busy", bus.busy, 0);
        bus.sync_in = 1; tick(); bus.sync_in = 0;
        check("rarm_ack", bus.commit_ack, 0);
        check("rarm_err", bus.commit_err, 0);
        check("rarm_pclr", bus.phase_clr, 0);
        tick();
        check("rarm_ack2", bus.commit_ack, 0);
        check("rarm_err2", bus.commit_err, 0);
        check("rarm_pclr2", bus.phase_clr, 0);
        check_active("rarm_ctrl");
        rd(1'b0, 1, 1, 16'h0, "rarm_shadow");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
